// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage core: EX operand forwarding,
// load-use bubble insertion, branch flushes, and pipeline hold while a NoC
// memory access from MEM is outstanding (with timeout into a sticky ERROR).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal operation, no NoC access outstanding
// MEM_WAIT | NoC access issued from MEM, waiting for mem_ack
// ERROR    | NoC never answered; pipeline frozen until reset
module hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Radd_E,
    input  logic             RegW_enable_E,
    input  logic             Result_src_E,
    input  logic [4:0]       Radd_M,
    input  logic             RegW_enable_M,
    input  logic [4:0]       Radd_W,
    input  logic             RegW_enable_W,
    input  logic             PCsrc_E,
    input  logic             mem_req_M,
    input  logic             mem_ack,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic [1:0]       Forward_A_E,
    output logic [1:0]       Forward_B_E,
    output logic             mem_busy,
    output logic             timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wide enough to hold TIMEOUT_CYCLES-1 even when TIMEOUT_CYCLES is 1.
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic lw_stall;
    logic mem_stall;
    logic stall_f_int;
    logic flush_d_int;
    logic flush_e_int;
    logic [1:0] fwd_a, fwd_b;

    // Operand forwarding: MEM ALU result beats WB result; x0 never forwards.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (RegW_enable_M && (Radd_M != 5'd0) && (Radd_M == Rs1_E))
            fwd_a = 2'b10;
        else if (RegW_enable_W && (Radd_W != 5'd0) && (Radd_W == Rs1_E))
            fwd_a = 2'b01;
        if (RegW_enable_M && (Radd_M != 5'd0) && (Radd_M == Rs2_E))
            fwd_b = 2'b10;
        else if (RegW_enable_W && (Radd_W != 5'd0) && (Radd_W == Rs2_E))
            fwd_b = 2'b01;
    end

    // Hazard detection and the resulting stall/flush controls.
    always_comb begin
        lw_stall  = Result_src_E & RegW_enable_E & (Radd_E != 5'd0) &
                    ((Radd_E == Rs1_D) | (Radd_E == Rs2_D));
        mem_stall = ((state_q == RUN) & mem_req_M & ~mem_ack) |
                    ((state_q == MEM_WAIT) & ~mem_ack) |
                    (state_q == ERROR);
        // A pending branch stays in EX under a memory hold and flushes on release.
        if (mem_stall) begin
            stall_f_int = 1'b1;
            flush_d_int = 1'b0;
            flush_e_int = 1'b0;
        end else begin
            stall_f_int = lw_stall;
            flush_d_int = PCsrc_E;
            flush_e_int = lw_stall | PCsrc_E;
        end
    end

    // While reset is asserted the pipeline registers are held clear and nothing forwards.
    always_comb begin
        Stall_F     = rst_n & stall_f_int;
        Stall_D     = rst_n & stall_f_int;
        Stall_E     = rst_n & mem_stall;
        Stall_M     = rst_n & mem_stall;
        Flush_D     = ~rst_n | flush_d_int;
        Flush_E     = ~rst_n | flush_e_int;
        Forward_A_E = rst_n ? fwd_a : 2'b00;
        Forward_B_E = rst_n ? fwd_b : 2'b00;
        mem_busy    = (state_q == MEM_WAIT);
        timeout     = (state_q == ERROR);
        stall_cnt   = stall_cnt_q;
        flush_cnt   = flush_cnt_q;
    end

    // NoC wait sequencing: an ack on the last allowed cycle still returns to RUN.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_req_M && !mem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack)
                    state_d = RUN;
                else if (wait_cnt_q == WAIT_LAST)
                    state_d = ERROR;
                else
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f_int && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_d_int && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State, wait counter and performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;

    localparam int T    = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Radd_E, Radd_M, Radd_W;
    logic RegW_enable_E, Result_src_E, RegW_enable_M, RegW_enable_W;
    logic PCsrc_E, mem_req_M, mem_ack;
    logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E;
    logic [1:0] Forward_A_E, Forward_B_E;
    logic mem_busy, timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Model: mode 0 = running, 1 = waiting on NoC, 2 = timed out.
    int m_mode, m_waited, m_stall, m_flush, errcyc;

    hazard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Radd_E(Radd_E), .RegW_enable_E(RegW_enable_E), .Result_src_E(Result_src_E),
        .Radd_M(Radd_M), .RegW_enable_M(RegW_enable_M),
        .Radd_W(Radd_W), .RegW_enable_W(RegW_enable_W),
        .PCsrc_E(PCsrc_E), .mem_req_M(mem_req_M), .mem_ack(mem_ack),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E),
        .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
        .mem_busy(mem_busy), .timeout(timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegW_enable_M && Radd_M != 0 && Radd_M == rs) return 2'b10;
        if (RegW_enable_W && Radd_W != 0 && Radd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_idle();
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
        Radd_E = 0; Radd_M = 0; Radd_W = 0;
        RegW_enable_E = 0; Result_src_E = 0; RegW_enable_M = 0; RegW_enable_W = 0;
        PCsrc_E = 0; mem_req_M = 0; mem_ack = 0;
    endtask

    // One clock: compare everything against the model mid-cycle, then advance the model.
    task automatic step();
        logic lw, hold, esf, efd, efe;
        @(negedge clk);
        lw = Result_src_E && RegW_enable_E && Radd_E != 0 &&
             (Radd_E == Rs1_D || Radd_E == Rs2_D);
        hold = (m_mode == 0 && mem_req_M && !mem_ack) ||
               (m_mode == 1 && !mem_ack) || (m_mode == 2);
        esf = hold ? 1'b1 : lw;
        efd = hold ? 1'b0 : PCsrc_E;
        efe = hold ? 1'b0 : (lw || PCsrc_E);
        chk("Forward_A_E", 32'(Forward_A_E), 32'(fwd(Rs1_E)));
        chk("Forward_B_E", 32'(Forward_B_E), 32'(fwd(Rs2_E)));
        chk("Stall_F", 32'(Stall_F), 32'(esf));
        chk("Stall_D", 32'(Stall_D), 32'(esf));
        chk("Stall_E", 32'(Stall_E), 32'(hold));
        chk("Stall_M", 32'(Stall_M), 32'(hold));
        chk("Flush_D", 32'(Flush_D), 32'(efd));
        chk("Flush_E", 32'(Flush_E), 32'(efe));
        chk("mem_busy", 32'(mem_busy), 32'(m_mode == 1));
        chk("timeout", 32'(timeout), 32'(m_mode == 2));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        @(posedge clk);
        if (esf && m_stall < CMAX) m_stall++;
        if (efd && m_flush < CMAX) m_flush++;
        case (m_mode)
            0: if (mem_req_M && !mem_ack) begin m_mode = 1; m_waited = 0; end
            1: if (mem_ack) m_mode = 0;
               else begin
                   m_waited++;
                   if (m_waited == T) m_mode = 2;
               end
            default: ;
        endcase
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges; checks the reset view of outputs.
    task automatic do_reset();
        Rs1_E = 5'd3; Rs2_E = 5'd4; Radd_M = 5'd3; RegW_enable_M = 1;
        Radd_W = 5'd4; RegW_enable_W = 1; mem_req_M = 1; mem_ack = 0;
        rst_n = 0;
        #1;
        chk("rst Stall_F", 32'(Stall_F), 0);
        chk("rst Stall_E", 32'(Stall_E), 0);
        chk("rst Stall_M", 32'(Stall_M), 0);
        chk("rst Flush_D", 32'(Flush_D), 1);
        chk("rst Flush_E", 32'(Flush_E), 1);
        chk("rst Forward_A_E", 32'(Forward_A_E), 0);
        chk("rst Forward_B_E", 32'(Forward_B_E), 0);
        chk("rst mem_busy", 32'(mem_busy), 0);
        chk("rst timeout", 32'(timeout), 0);
        chk("rst stall_cnt", 32'(stall_cnt), 0);
        chk("rst flush_cnt", 32'(flush_cnt), 0);
        m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; errcyc = 0;
        @(negedge clk);
        rst_n = 1;
        set_idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        #1;
        do_reset();

        // Forwarding priority and x0 suppression
        Rs1_E = 5; Radd_M = 5; RegW_enable_M = 1; Radd_W = 5; RegW_enable_W = 1;
        #1 chk("lit fwd MEM", 32'(Forward_A_E), 2);
        step();
        RegW_enable_M = 0;
        #1 chk("lit fwd WB", 32'(Forward_A_E), 1);
        step();
        RegW_enable_M = 1; Radd_M = 0; Radd_W = 0;
        #1 chk("lit fwd x0", 32'(Forward_A_E), 0);
        step();
        set_idle();

        // Load-use bubble
        Result_src_E = 1; RegW_enable_E = 1; Radd_E = 7; Rs2_D = 7;
        #1 chk("lit lw Stall_F", 32'(Stall_F), 1);
        chk("lit lw Flush_E", 32'(Flush_E), 1);
        step();
        chk("lit lw stall_cnt", 32'(stall_cnt), 1);
        Radd_E = 0; Rs2_D = 0;
        #1 chk("lit lw x0", 32'(Stall_F), 0);
        step();
        set_idle();

        // Branch flush
        PCsrc_E = 1;
        #1 chk("lit br Flush_D", 32'(Flush_D), 1);
        chk("lit br Flush_E", 32'(Flush_E), 1);
        chk("lit br Stall_F", 32'(Stall_F), 0);
        step();
        chk("lit br flush_cnt", 32'(flush_cnt), 1);

        // NoC wait of three cycles with a branch pending in EX
        mem_req_M = 1; mem_ack = 0; PCsrc_E = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("lit noc Stall_M", 32'(Stall_M), 1);
            chk("lit noc Flush_D", 32'(Flush_D), 0);
            chk("lit noc mem_busy", 32'(mem_busy), (i == 0) ? 0 : 1);
            step();
        end
        mem_ack = 1;
        #1 chk("lit noc release Stall_F", 32'(Stall_F), 0);
        chk("lit noc release Flush_D", 32'(Flush_D), 1);
        step();
        set_idle();
        #1 chk("lit noc back to RUN", 32'(mem_busy), 0);
        step();

        // Ack on the last permitted MEM_WAIT cycle still returns to RUN
        mem_req_M = 1;
        for (int i = 0; i < T; i++) step();
        mem_ack = 1;
        step();
        set_idle();
        #1 chk("lit late ack timeout", 32'(timeout), 0);
        chk("lit late ack busy", 32'(mem_busy), 0);
        step();

        // Timeout after 1 + T stalled cycles, then sticky
        mem_req_M = 1;
        for (int i = 0; i < T + 1; i++) step();
        #1 chk("lit timeout set", 32'(timeout), 1);
        mem_ack = 1;
        step();
        step();
        chk("lit timeout sticky", 32'(timeout), 1);
        chk("lit timeout Stall_F", 32'(Stall_F), 1);
        do_reset();

        // Stall counter saturation
        Result_src_E = 1; RegW_enable_E = 1; Radd_E = 9; Rs1_D = 9;
        for (int i = 0; i < 20; i++) step();
        chk("lit stall_cnt saturate", 32'(stall_cnt), 15);
        set_idle();
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            Rs1_D = 5'($urandom_range(0, 7)); Rs2_D = 5'($urandom_range(0, 7));
            Rs1_E = 5'($urandom_range(0, 7)); Rs2_E = 5'($urandom_range(0, 7));
            Radd_E = 5'($urandom_range(0, 7)); Radd_M = 5'($urandom_range(0, 7));
            Radd_W = 5'($urandom_range(0, 7));
            RegW_enable_E = 1'($urandom); Result_src_E = 1'($urandom);
            RegW_enable_M = 1'($urandom); RegW_enable_W = 1'($urandom);
            PCsrc_E = ($urandom_range(0, 4) == 0);
            if (m_mode != 0) mem_req_M = 1;
            else mem_req_M = ($urandom_range(0, 5) == 0);
            mem_ack = ($urandom_range(0, 2) == 0);
            step();
            if (m_mode == 2) errcyc++;
            if (errcyc > 3) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
